// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one shared 1-bit slice evaluates AND/OR/ADD with optional
// operand inversion, LSB first, one bit per clock; results appear only on completion.
module bit_serial_alu #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-2:0] sh;

    logic             ai;
    logic             bi;
    logic             sbit;
    logic             cnext;
    logic             last;
    logic [WIDTH-1:0] shifted;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- 1-bit slice ----------------
    always_comb begin
        ai    = a_q[cnt] ^ op_q[3];
        bi    = b_q[cnt] ^ op_q[2];
        sbit  = 1'b0;
        cnext = carry;
        unique case (op_q[1:0])
            2'b00: sbit = ai & bi;
            2'b01: sbit = ai | bi;
            2'b10: begin
                sbit  = ai ^ bi ^ carry;
                cnext = (ai & bi) | (ai & carry) | (bi & carry);
            end
            default: sbit = 1'b0;
        endcase
    end

    assign last    = (cnt == CW'(WIDTH - 1));
    // New bit enters at the top; after WIDTH shifts bit 0 has reached position 0.
    assign shifted = {sbit, sh};

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sh       <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            CarryOut <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= ALUOp;
                        cnt   <= '0;
                        // Preloading carry with the b-invert bit turns ~b + 1 into two's-complement subtract.
                        carry <= ALUOp[2];
                    end
                end
                RUN: begin
                    sh    <= shifted[WIDTH-1:1];
                    carry <= cnext;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        Result   <= shifted;
                        Zero     <= (shifted == '0);
                        CarryOut <= (op_q[1:0] == 2'b10) ? cnext : 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu (WIDTH=8): directed scenarios plus
// random operations against an arithmetic reference model.
module tb_bit_serial_alu;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   ALUOp;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] Result;
    logic         Zero;
    logic         CarryOut;
    logic         busy;
    logic         done;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0] exp_res = '0;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ALUOp    (ALUOp),
        .a        (a),
        .b        (b),
        .Result   (Result),
        .Zero     (Zero),
        .CarryOut (CarryOut),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, {carry, result}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [3:0] op);
        logic [W-1:0] xi;
        logic [W-1:0] yi;
        logic [W:0]   r;
        xi = op[3] ? ~x : x;
        yi = op[2] ? ~y : y;
        case (op[1:0])
            2'b00:   r = {1'b0, xi & yi};
            2'b01:   r = {1'b0, xi | yi};
            2'b10:   r = {1'b0, xi} + {1'b0, yi} + (W+1)'(op[2]);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [3:0] top,
                          input bit disturb);
        logic [W:0] m;
        int         n;
        bit         clean;
        m     = model(ta, tb, top);
        a     = ta;
        b     = tb;
        ALUOp = top;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        clean = 1'b1;
        while (busy && n < 20) begin
            if (Result !== exp_res || done) clean = 1'b0;
            if (disturb) begin
                a     = W'($urandom);
                b     = W'($urandom);
                ALUOp = 4'($urandom);
                start = (n == 3);
            end
            n++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("latency", 32'(n), 32'(W));
        check("run_no_partial", 32'(clean), 32'd1);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("result", 32'(Result), 32'(m[W-1:0]));
        check("zero", 32'(Zero), 32'(m[W-1:0] == '0));
        check("carry", 32'(CarryOut), 32'(m[W]));
        exp_res = m[W-1:0];
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin : stim
        int  n;
        int  t1;
        int  t2;
        bit  quiet;

        reset = 1'b1;
        start = 1'b0;
        ALUOp = '0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_result", 32'(Result), 32'd0);
        check("rst_flags", {29'd0, Zero, CarryOut, busy | done}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // ADD with wraparound
        run_op(8'hFF, 8'h01, 4'b0010, 1'b0);
        check("add_const", {23'd0, CarryOut, Result}, {23'd0, 1'b1, 8'h00});

        // SUB
        run_op(8'h05, 8'h07, 4'b0110, 1'b0);
        check("sub_const", {22'd0, Zero, CarryOut, Result}, {22'd0, 1'b0, 1'b0, 8'hFE});
        run_op(8'h07, 8'h07, 4'b0110, 1'b0);
        check("sub_eq_const", {22'd0, Zero, CarryOut, Result}, {22'd0, 1'b1, 1'b1, 8'h00});

        // logic ops
        run_op(8'hF0, 8'h3C, 4'b0000, 1'b0);
        check("and_const", 32'(Result), 32'h30);
        run_op(8'hF0, 8'h3C, 4'b0001, 1'b0);
        check("or_const", 32'(Result), 32'hFC);
        run_op(8'hF0, 8'h3C, 4'b1100, 1'b0);
        check("nor_const", 32'(Result), 32'h03);

        // input stability: inputs scrambled and start pulsed during RUN
        run_op(8'h5A, 8'h33, 4'b0010, 1'b1);
        run_op(8'hC3, 8'h81, 4'b0110, 1'b1);

        // reset abort at bit 4
        a     = 8'h12;
        b     = 8'h34;
        ALUOp = 4'b0010;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("abort_result", 32'(Result), 32'd0);
        check("abort_flags", {28'd0, Zero, CarryOut, busy, done}, 32'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy || done) quiet = 1'b0;
        end
        check("abort_no_done", 32'(quiet), 32'd1);
        #2;
        reset   = 1'b0;
        exp_res = '0;
        run_op(8'h12, 8'h34, 4'b0010, 1'b0);

        // random operations
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 4'($urandom), (i % 5) == 0);
        end

        // back-to-back with start held, reserved op
        a     = W'($urandom);
        b     = W'($urandom);
        ALUOp = 4'b0011;
        start = 1'b1;
        n  = 0;
        t1 = -1;
        t2 = -1;
        while (t2 < 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                if (t1 < 0) t1 = n;
                else        t2 = n;
            end
        end
        start = 1'b0;
        check("b2b_spacing", 32'(t2 - t1), 32'(W + 2));
        check("b2b_result", {22'd0, Zero, CarryOut, Result}, {22'd0, 1'b1, 1'b0, 8'h00});
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_stops", {30'd0, busy, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
